// File: rtl/arm_mc_pkg.sv
// Shared encodings for the multicycle ARM main control FSM.
// Holds state codes, datapath mux encodings, opcode classes and the control-field bundle.
package arm_mc_pkg;

  localparam int unsigned StFetch  = 0;
  localparam int unsigned StDecode = 1;
  localparam int unsigned StMemAdr = 2;
  localparam int unsigned StMemRd  = 3;
  localparam int unsigned StMemWb  = 4;
  localparam int unsigned StMemWr  = 5;
  localparam int unsigned StExecR  = 6;
  localparam int unsigned StExecI  = 7;
  localparam int unsigned StAluWb  = 8;
  localparam int unsigned StBranch = 9;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  typedef struct packed {
    logic       adr_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       alu_op;
    logic [1:0] result_src;
    logic       ir_write;
    logic       next_pc;
    logic       reg_w;
    logic       mem_w;
    logic       branch;
  } ctrl_t;

endpackage

// File: rtl/mc_state_decode.sv
// Combinational state-to-control-field table for the multicycle main FSM.
// Illegal state codes decode to an all-zero control bundle.
module mc_state_decode
  import arm_mc_pkg::*;
#(
  parameter int unsigned STATE_W = 4
) (
  input  logic [STATE_W-1:0] state_i,
  output ctrl_t              ctrl_o
);

  always_comb begin
    ctrl_o = '0;
    case (state_i)
      STATE_W'(StFetch): begin
        ctrl_o.alu_src_a  = 1'b1;
        ctrl_o.alu_src_b  = SRCB_FOUR;
        ctrl_o.result_src = RES_ALURESULT;
        ctrl_o.ir_write   = 1'b1;
        ctrl_o.next_pc    = 1'b1;
      end
      STATE_W'(StDecode): begin
        ctrl_o.alu_src_a  = 1'b1;
        ctrl_o.alu_src_b  = SRCB_FOUR;
        ctrl_o.result_src = RES_ALURESULT;
      end
      STATE_W'(StMemAdr): ctrl_o.alu_src_b = SRCB_IMM;
      STATE_W'(StMemRd):  ctrl_o.adr_src = 1'b1;
      STATE_W'(StMemWb): begin
        ctrl_o.result_src = RES_DATA;
        ctrl_o.reg_w      = 1'b1;
      end
      STATE_W'(StMemWr): begin
        ctrl_o.adr_src = 1'b1;
        ctrl_o.mem_w   = 1'b1;
      end
      STATE_W'(StExecR): begin
        ctrl_o.alu_src_b = SRCB_REG;
        ctrl_o.alu_op    = 1'b1;
      end
      STATE_W'(StExecI): begin
        ctrl_o.alu_src_b = SRCB_IMM;
        ctrl_o.alu_op    = 1'b1;
      end
      STATE_W'(StAluWb): begin
        ctrl_o.result_src = RES_ALUOUT;
        ctrl_o.reg_w      = 1'b1;
      end
      STATE_W'(StBranch): begin
        ctrl_o.alu_src_b  = SRCB_IMM;
        ctrl_o.result_src = RES_ALURESULT;
        ctrl_o.branch     = 1'b1;
      end
      default: ctrl_o = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_main_fsm.sv
// Main control FSM for the multicycle ARM datapath: state register, sequencing, write gating.
// Optional MULTICYCLE_MEM_WAIT_EN adds MemReady to stall FETCH, MEMRD and MEMWR.
module multicycle_main_fsm
  import arm_mc_pkg::*;
#(
  parameter int unsigned STATE_W = 4
) (
  input  logic               CLK,
  input  logic               Reset,
  input  logic [1:0]         Op,
  input  logic [5:0]         Funct,
  input  logic [3:0]         Rd,
  input  logic               CondEx,
`ifdef MULTICYCLE_MEM_WAIT_EN
  input  logic               MemReady,
`endif
  output logic               IRWrite,
  output logic               AdrSrc,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic               ALUOp,
  output logic [1:0]         ResultSrc,
  output logic               PCWrite,
  output logic               RegWrite,
  output logic               MemWrite,
  output logic               InstrDone,
  output logic [STATE_W-1:0] State
);

  localparam logic [STATE_W-1:0] SFetch  = STATE_W'(StFetch);
  localparam logic [STATE_W-1:0] SDecode = STATE_W'(StDecode);
  localparam logic [STATE_W-1:0] SMemAdr = STATE_W'(StMemAdr);
  localparam logic [STATE_W-1:0] SMemRd  = STATE_W'(StMemRd);
  localparam logic [STATE_W-1:0] SMemWb  = STATE_W'(StMemWb);
  localparam logic [STATE_W-1:0] SMemWr  = STATE_W'(StMemWr);
  localparam logic [STATE_W-1:0] SExecR  = STATE_W'(StExecR);
  localparam logic [STATE_W-1:0] SExecI  = STATE_W'(StExecI);
  localparam logic [STATE_W-1:0] SAluWb  = STATE_W'(StAluWb);
  localparam logic [STATE_W-1:0] SBranch = STATE_W'(StBranch);

  logic [STATE_W-1:0] state_q, state_d;
  ctrl_t              ctrl;
  logic               mem_ready;
  logic               next_pc, pcs;
  logic               unused_funct;

`ifdef MULTICYCLE_MEM_WAIT_EN
  assign mem_ready = MemReady;
`else
  assign mem_ready = 1'b1;
`endif

  assign unused_funct = ^Funct[4:1];

  mc_state_decode #(
    .STATE_W (STATE_W)
  ) u_decode (
    .state_i (state_q),
    .ctrl_o  (ctrl)
  );

  always_ff @(posedge CLK) begin
    if (Reset) state_q <= SFetch;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = SFetch;
    case (state_q)
      SFetch:  state_d = mem_ready ? SDecode : SFetch;
      SDecode: begin
        case (Op)
          OP_MEM:  state_d = SMemAdr;
          OP_DP:   state_d = Funct[5] ? SExecI : SExecR;
          OP_BR:   state_d = SBranch;
          default: state_d = SFetch;
        endcase
      end
      SMemAdr: state_d = Funct[0] ? SMemRd : SMemWr;
      SMemRd:  state_d = mem_ready ? SMemWb : SMemRd;
      SMemWb:  state_d = SFetch;
      SMemWr:  state_d = mem_ready ? SFetch : SMemWr;
      SExecR:  state_d = SAluWb;
      SExecI:  state_d = SAluWb;
      SAluWb:  state_d = SFetch;
      SBranch: state_d = SFetch;
      default: state_d = SFetch;
    endcase
  end

  // Reset overrides every write strobe so an abandoned instruction leaves no trace.
  always_comb begin
    next_pc   = ctrl.next_pc & mem_ready;
    pcs       = (ctrl.reg_w & (Rd == 4'hF)) | ctrl.branch;
    IRWrite   = ~Reset & ctrl.ir_write & mem_ready;
    PCWrite   = ~Reset & (next_pc | (pcs & CondEx));
    RegWrite  = ~Reset & ctrl.reg_w & CondEx;
    MemWrite  = ~Reset & ctrl.mem_w & CondEx;
    InstrDone = ~Reset & ((state_q == SMemWb) | ((state_q == SMemWr) & mem_ready) |
                          (state_q == SAluWb) | (state_q == SBranch) |
                          ((state_q == SDecode) & (Op == 2'b11)));
    AdrSrc    = ctrl.adr_src;
    ALUSrcA   = ctrl.alu_src_a;
    ALUSrcB   = ctrl.alu_src_b;
    ALUOp     = ctrl.alu_op;
    ResultSrc = ctrl.result_src;
    State     = state_q;
  end

endmodule
